fade_buffer: RTL
================

FADE_BUFFER -- requirements
Module: fade_buffer

Interface
REQ-001 Parameter DIV, default 512: clocks between fade updates; legal range 272..65535.
REQ-002 Parameter N, default 32: fader channels; fixed to match the 5-bit channel field.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 enable  in  1  1 = update timer runs; 0 = timer holds.
REQ-006 fade_start  out  1  one-cycle pulse requesting a fader frame.
REQ-007 fade_t_index  out  25  time index presented with fade_start.
REQ-008 fade_dv  in  1  fader output valid.
REQ-009 fade_chan  in  5  channel of the current fader output.
REQ-010 fade_imag, fade_real  in  16 each  signed fade coefficient.
REQ-011 rd_chan  in  5  consumer read address.
REQ-012 rd_imag, rd_real  out  16 each  signed coefficient from the front bank.
REQ-013 frame_valid  out  1  sticky; 1 once the first complete frame has been swapped in.
REQ-014 frame_count  out  16  number of completed swaps; wraps modulo 2^16.
REQ-015 overrun  out  1  sticky error flag.

Function
REQ-016 Timer counts DIV-1 down to 0 while enable=1, reloads DIV-1 at 0, and holds its value while enable=0.
REQ-017 At timer=0 with state IDLE: fade_start=1 for exactly one cycle, fade_t_index=t_cnt on that cycle, then t_cnt increments, wrapping 2^25-1 to 0.
REQ-018 fade_t_index holds its value between pulses.
REQ-019 FSM states: IDLE, COLLECT, SWAP.
REQ-020 Transitions: IDLE to COLLECT on fade_start; COLLECT to SWAP on the cycle the N-th fade_dv is accepted; SWAP to IDLE after one cycle.
REQ-021 In COLLECT, each fade_dv writes {imag, real} into the back bank at address fade_chan and increments rx_cnt; arrival order is arbitrary.
REQ-022 fade_dv outside COLLECT is ignored: no write, no count.
REQ-023 rx_cnt counts pulses, not unique channels; duplicates overwrite the same address.
REQ-024 SWAP toggles the bank pointer, sets frame_valid=1, increments frame_count, and clears rx_cnt.
REQ-025 If the timer reaches 0 while not IDLE: no fade_start is issued, t_cnt does not increment, overrun is set to 1, and collection continues.
REQ-026 Read path has 1-cycle latency: rd_* on cycle k+1 reflect rd_chan sampled at edge k.
REQ-027 Bank selection for reads uses the pointer value before the edge; a read sampled on the SWAP cycle returns the old front bank.
REQ-028 Reads never observe the back bank and never see a partially written frame.
REQ-029 Before frame_valid=1, rd_* read zeros.
REQ-030 enable falling during COLLECT does not abort the frame.

Reset
REQ-031 On reset: state=IDLE, timer=DIV-1, t_cnt=0, fade_start=0, fade_t_index=0, bank pointer=0, rx_cnt=0.
REQ-032 On reset: frame_valid=0, frame_count=0, overrun=0, rd_imag=0, rd_real=0.
REQ-033 Reset mid-COLLECT discards the partial frame.
REQ-034 Both banks are cleared to zero over the N cycles following reset; fade_start is suppressed until clearing completes.

Structure
REQ-035 Package fade_pack holds: N_CHAN=32, W_CHAN=5, W_T=25, W_Z=16, typedef fade_t {signed imag[16], signed real[16]}, and the FSM state enum.
REQ-036 One sub-module, fade_dpram: 64x32 simple dual-port RAM, 1 write port and 1 registered read port; address = {bank, chan}.

Verification
REQ-037 DIV=300, enable=1 after reset and clearing: fade_start pulses at 300-cycle spacing with t_index 0, 1, 2, ...
REQ-038 Fader model returns chan c: imag=c, real=-c, order 31..0, every 8 cycles: after SWAP, rd_chan=5 gives rd_imag=5, rd_real=-5, frame_valid=1, frame_count=1.
REQ-039 Read rd_chan=7 continuously across a SWAP where the new frame has imag=100+c: old value is returned through the SWAP-cycle read, 107 on the next read.
REQ-040 Model delivers only 31 dv pulses: next timer expiry sets overrun=1, no fade_start, t_index not advanced; the 32nd pulse then completes the swap.
REQ-041 enable=0 for 1000 cycles mid-count: no fade_start during that window; the timer resumes from the held value.
REQ-042 reset asserted after 10 of 32 pulses: all outputs return to reset values, and reads return 0 after clearing.

Source files
------------

// File: rtl/fade_buffer_pkg.sv
// Shared sizes, coefficient record and controller states for the fade double buffer.
package fade_pack;
  localparam int N_CHAN = 32;
  localparam int W_CHAN = 5;
  localparam int W_T    = 25;
  localparam int W_Z    = 16;

  typedef struct packed {
    logic signed [W_Z-1:0] im;
    logic signed [W_Z-1:0] re;
  } fade_t;

  typedef enum logic [1:0] {IDLE, COLLECT, SWAP} state_e;
endpackage

// File: rtl/fade_buffer_dpram.sv
// Coefficient store for both banks (address = {bank, chan}); one write port, registered read.
// One-cycle read latency, no flow control.
module fade_dpram
  import fade_pack::*;
(
  input  logic            clk,
  input  logic            wr_en,
  input  logic [W_CHAN:0] wr_addr,
  input  fade_t           wr_dat,
  input  logic [W_CHAN:0] rd_addr,
  output fade_t           rd_dat
);
  fade_t mem [2*N_CHAN];
  fade_t rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    rd_dat_q <= mem[rd_addr];
  end

  assign rd_dat = rd_dat_q;
endmodule

// File: rtl/fade_buffer.sv
// Paces fader frames, collects N coefficients into a back bank and swaps it to the reader.
// Reads have 1-cycle latency; the fader is never stalled, a late frame only raises overrun.
module fade_buffer
  import fade_pack::*;
#(
  parameter int DIV = 512,
  parameter int N   = N_CHAN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  fade_start,
  output logic [W_T-1:0]        fade_t_index,
  input  logic                  fade_dv,
  input  logic [W_CHAN-1:0]     fade_chan,
  input  logic signed [W_Z-1:0] fade_imag,
  input  logic signed [W_Z-1:0] fade_real,
  input  logic [W_CHAN-1:0]     rd_chan,
  output logic signed [W_Z-1:0] rd_imag,
  output logic signed [W_Z-1:0] rd_real,
  output logic                  frame_valid,
  output logic [15:0]           frame_count,
  output logic                  overrun
);
  localparam logic [15:0]     TMAX  = 16'(DIV - 1);
  localparam logic [W_CHAN:0] LAST  = (W_CHAN+1)'(N - 1);
  localparam logic [W_CHAN:0] CLR_N = (W_CHAN+1)'(N);
  localparam logic [W_CHAN:0] ONE_C = (W_CHAN+1)'(1);

  state_e             state_q, state_d;
  logic [15:0]        timer_q, timer_d;
  logic [W_T-1:0]     t_cnt_q, t_cnt_d;
  logic [W_T-1:0]     fade_t_index_q, fade_t_index_d;
  logic               fade_start_q, fade_start_d;
  logic               bank_q, bank_d;
  logic [W_CHAN:0]    rx_cnt_q, rx_cnt_d;
  logic               frame_valid_q, frame_valid_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               overrun_q, overrun_d;
  logic [W_CHAN:0]    clr_cnt_q, clr_cnt_d;
  logic [2*N_CHAN-1:0] wr_mask_q, wr_mask_d;
  logic               rd_ok_q, rd_ok_d;

  logic               tick, clr_done, ram_we;
  logic [W_CHAN:0]    ram_waddr;
  fade_t              ram_wdat, ram_rdat;

  assign tick     = enable && (timer_q == '0);
  assign clr_done = (clr_cnt_q == CLR_N);

  // wr_mask marks entries written since reset; unmarked entries read as the cleared value 0
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    t_cnt_d        = t_cnt_q;
    fade_t_index_d = fade_t_index_q;
    fade_start_d   = 1'b0;
    bank_d         = bank_q;
    rx_cnt_d       = rx_cnt_q;
    frame_valid_d  = frame_valid_q;
    frame_count_d  = frame_count_q;
    overrun_d      = overrun_q;
    clr_cnt_d      = clr_cnt_q;
    wr_mask_d      = wr_mask_q;
    ram_we         = 1'b0;
    ram_waddr      = {~bank_q, fade_chan};
    ram_wdat       = '{im: fade_imag, re: fade_real};

    if (enable) timer_d = tick ? TMAX : timer_q - 16'd1;
    if (!clr_done) clr_cnt_d = clr_cnt_q + ONE_C;

    case (state_q)
      IDLE: begin
        if (tick && clr_done) begin
          fade_start_d   = 1'b1;
          fade_t_index_d = t_cnt_q;
          t_cnt_d        = t_cnt_q + W_T'(1);
          state_d        = COLLECT;
        end
      end
      COLLECT: begin
        if (tick) overrun_d = 1'b1;
        if (fade_dv) begin
          ram_we               = 1'b1;
          wr_mask_d[ram_waddr] = 1'b1;
          rx_cnt_d             = rx_cnt_q + ONE_C;
          if (rx_cnt_q == LAST) state_d = SWAP;
        end
      end
      SWAP: begin
        if (tick) overrun_d = 1'b1;
        bank_d        = ~bank_q;
        frame_valid_d = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
        rx_cnt_d      = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_ok_d = frame_valid_q && wr_mask_q[{bank_q, rd_chan}];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= TMAX;
      t_cnt_q        <= '0;
      fade_t_index_q <= '0;
      fade_start_q   <= 1'b0;
      bank_q         <= 1'b0;
      rx_cnt_q       <= '0;
      frame_valid_q  <= 1'b0;
      frame_count_q  <= '0;
      overrun_q      <= 1'b0;
      clr_cnt_q      <= '0;
      wr_mask_q      <= '0;
      rd_ok_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      t_cnt_q        <= t_cnt_d;
      fade_t_index_q <= fade_t_index_d;
      fade_start_q   <= fade_start_d;
      bank_q         <= bank_d;
      rx_cnt_q       <= rx_cnt_d;
      frame_valid_q  <= frame_valid_d;
      frame_count_q  <= frame_count_d;
      overrun_q      <= overrun_d;
      clr_cnt_q      <= clr_cnt_d;
      wr_mask_q      <= wr_mask_d;
      rd_ok_q        <= rd_ok_d;
    end
  end

  fade_dpram u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_dat  (ram_wdat),
    .rd_addr ({bank_q, rd_chan}),
    .rd_dat  (ram_rdat)
  );

  assign fade_start   = fade_start_q;
  assign fade_t_index = fade_t_index_q;
  assign frame_valid  = frame_valid_q;
  assign frame_count  = frame_count_q;
  assign overrun      = overrun_q;
  assign rd_imag      = rd_ok_q ? ram_rdat.im : '0;
  assign rd_real      = rd_ok_q ? ram_rdat.re : '0;
endmodule
